// File: rtl/painel_scroll_ctrl.sv
// Scroll sequencer for the 16-bit panel line registers: loads the preset, then
// issues one shift code every DIVsel+1 clocks, with pause, stop and loop control.
module painel_scroll_ctrl #(
    parameter int DIV0 = 50000000,
    parameter int DIV1 = 25000000,
    parameter int DIV2 = 12500000,
    parameter int DIV3 = 6250000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       start,
    input  logic       stop,
    input  logic       pause,
    input  logic       dir,
    input  logic [1:0] speed,
    input  logic       loop,
    output logic       ch1,
    output logic       ch0,
    output logic       busy,
    output logic       done,
    output logic [3:0] pos
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT,
        SHIFT,
        PAUSED,
        DONE
    } state_t;

    state_t      state;
    logic [31:0] tick;
    logic [31:0] limit;
    logic        dirlat;
    logic        looplat;
    logic [1:0]  speedlat;
    logic [1:0]  shiftcode;

    // Terminal count of the wait phase, chosen by the speed latched at LOAD.
    always_comb begin
        limit = 32'(DIV0 - 1);
        case (speedlat)
            2'd0: limit = 32'(DIV0 - 1);
            2'd1: limit = 32'(DIV1 - 1);
            2'd2: limit = 32'(DIV2 - 1);
            2'd3: limit = 32'(DIV3 - 1);
            default: limit = 32'(DIV0 - 1);
        endcase
    end

    assign shiftcode = dirlat ? 2'b01 : 2'b10;

    // Single state machine; every output is registered alongside the state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            tick       <= '0;
            dirlat     <= 1'b0;
            looplat    <= 1'b0;
            speedlat   <= 2'd0;
            {ch1, ch0} <= 2'b00;
            busy       <= 1'b0;
            done       <= 1'b0;
            pos        <= 4'd0;
        end else begin
            {ch1, ch0} <= 2'b00;
            done       <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (start && !stop) begin
                        state      <= LOAD;
                        {ch1, ch0} <= 2'b11;
                        busy       <= 1'b1;
                        pos        <= 4'd0;
                        tick       <= '0;
                        dirlat     <= dir;
                        looplat    <= loop;
                        speedlat   <= speed;
                    end
                end
                LOAD: begin
                    if (stop) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (stop) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (pause) begin
                        state <= PAUSED;
                    end else if (tick == limit) begin
                        tick       <= '0;
                        state      <= SHIFT;
                        {ch1, ch0} <= shiftcode;
                        pos        <= pos + 4'd1;
                    end else begin
                        tick <= tick + 32'd1;
                    end
                end
                // The release cycle counts like a wait cycle, so a pause held
                // for N clocks delays the next shift by exactly N clocks.
                PAUSED: begin
                    if (stop) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (!pause) begin
                        if (tick == limit) begin
                            tick       <= '0;
                            state      <= SHIFT;
                            {ch1, ch0} <= shiftcode;
                            pos        <= pos + 4'd1;
                        end else begin
                            tick  <= tick + 32'd1;
                            state <= WAIT;
                        end
                    end
                end
                SHIFT: begin
                    if (stop) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (pos == 4'd0 && !looplat) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state <= WAIT;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/painel_scroll_ctrl.md
PAINEL_SCROLL_CTRL -- requirements
Module: painel_scroll_ctrl

Interface
REQ-001 SHALL have parameter DIV0, default 50000000, shift period in clocks for speed=0.
REQ-002 SHALL have parameter DIV1, default 25000000, shift period for speed=1.
REQ-003 SHALL have parameter DIV2, default 12500000, shift period for speed=2.
REQ-004 SHALL have parameter DIV3, default 6250000, shift period for speed=3; all DIVn >= 2.
REQ-005 SHALL have port CLK  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port RST  input  1  synchronous, active-high reset.
REQ-007 SHALL have port start  input  1  begin a scroll sequence (sampled in IDLE only).
REQ-008 SHALL have port stop  input  1  abort the sequence.
REQ-009 SHALL have port pause  input  1  level; freezes the scroll while high.
REQ-010 SHALL have port dir  input  1  0 = shift left, 1 = shift right.
REQ-011 SHALL have port speed  input  2  selects DIV0..DIV3.
REQ-012 SHALL have port loop  input  1  1 = scroll continuously, 0 = one full 16-step revolution.
REQ-013 SHALL have ports ch1,ch0  output  1 each  mode code to the 16-bit line registers: 00 hold, 01 shift right, 10 shift left, 11 load preset.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-015 SHALL have port done  output  1  one-cycle pulse on completion of a non-loop revolution.
REQ-016 SHALL have port pos  output  4  shifts issued since LOAD, modulo 16.

Function
REQ-017 SHALL implement states IDLE, LOAD, WAIT, SHIFT, PAUSED, DONE; all outputs registered.
REQ-018 IDLE: ch=00; on start=1 and stop=0 SHALL go to LOAD next cycle.
REQ-019 LOAD: ch=11 for exactly one cycle; pos<=0; dir, speed, loop latched; tick counter cleared; next state WAIT.
REQ-020 WAIT: ch=00; tick counter increments each cycle; on count = DIVsel-1 SHALL clear counter and go to SHIFT.
REQ-021 SHIFT: ch=10 (dir=0) or 01 (dir=1) for exactly one cycle; pos<=pos+1 wrapping 15->0.
REQ-022 After SHIFT, if the incremented pos is 0 and loop=0 SHALL go to DONE, else WAIT.
REQ-023 DONE: ch=00, done=1 for one cycle, then IDLE; pos retains 0.
REQ-024 Latency: start sampled at edge t -> ch=11 during cycle t+1, first shift code during cycle t+2+DIVsel.
REQ-025 Shift cadence SHALL be exactly DIVsel+1 clocks between consecutive shift codes.
REQ-026 pause=1 in WAIT SHALL enter PAUSED next cycle with counter frozen; pause=0 returns to WAIT resuming count.
REQ-027 pause in LOAD or SHIFT SHALL take effect only after that one-cycle state completes (no truncated codes).
REQ-028 stop=1 in any non-IDLE state SHALL go to IDLE next cycle, ch=00, no done pulse, pos frozen.
REQ-029 start and stop both high in IDLE: stop wins, remain IDLE.
REQ-030 start while busy SHALL be ignored; dir/speed/loop changes while busy ignored until next LOAD.
REQ-031 stop has priority over pause; pause has priority over terminal count.
REQ-032 ch SHALL never be 11 outside LOAD and never a shift code outside SHIFT.

Reset
REQ-033 RST=1 at any edge SHALL force IDLE, ch=00, busy=0, done=0, pos=0, tick counter 0, latched dir/speed/loop 0.
REQ-034 RST SHALL override start, stop and pause; a mid-sequence reset emits no done pulse.

Verification (DIV0=3, DIV1=5, DIV2=7, DIV3=9)
REQ-035 Reset, start pulse, speed=0, dir=0, loop=0 -> ch=11 one cycle, then 16 codes 10 spaced 4 clocks, pos 1..15,0, done one pulse, busy low after.
REQ-036 speed=3, dir=1, loop=1 -> codes 01 every 10 clocks; pos wraps 15->0 with no done; stop after 20 shifts -> IDLE, pos=4.
REQ-037 pause high 12 clocks mid-WAIT -> no shift code during pause; next shift arrives exactly 12 clocks later than unpaused.
REQ-038 start and stop same cycle in IDLE -> busy stays 0, ch stays 00.
REQ-039 RST asserted during SHIFT -> next cycle ch=00, pos=0, busy=0, done=0.
REQ-040 start, dir or speed toggled while busy -> no new LOAD, cadence and direction unchanged.
